// File: rtl/ber_pkg.sv
// Shared definitions for the BER synchroniser: lane FSM encoding and
// default parameter values.
package ber_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } lane_state_t;

  localparam int DEF_NCH        = 2;
  localparam int DEF_MAX_DELAY  = 511;
  localparam int DEF_WIN_LEN    = 511;
  localparam int DEF_RELOCK_THR = 32;
  localparam int DEF_CNT_W      = 32;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ber_lane.sv
// One BER lane: sx history, delay search / lock FSM, error and bit counters.
// The window counter and error accumulator are shared by search trials and
// the lock monitor, so windows stay contiguous across state changes.
module ber_lane
  import ber_pkg::*;
#(
  parameter int MAX_DELAY  = DEF_MAX_DELAY,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int RELOCK_THR = DEF_RELOCK_THR,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DLY_W      = $clog2(DEF_MAX_DELAY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sx,
  input  logic              dx,
  input  logic              clear,
  output lane_state_t       state,
  output logic [DLY_W-1:0]  delay,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  bit_count,
  output logic              error_flag
);

  localparam int WC_W = cnt_width(WIN_LEN);
  localparam int EW   = $clog2(WIN_LEN + 1);
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(MAX_DELAY - 1);

  lane_state_t          state_q, state_d;
  logic [MAX_DELAY-2:0] hist_q, hist_d;
  logic [DLY_W-1:0]     trial_q, trial_d;
  logic [DLY_W-1:0]     min_dly_q, min_dly_d;
  logic [DLY_W-1:0]     delay_q, delay_d;
  logic [WC_W-1:0]      win_q, win_d;
  logic [EW-1:0]        acc_q, acc_d;
  logic [EW-1:0]        min_q, min_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic                 flag_q, flag_d;

  // taps[k] is sx delayed by k enabled samples; taps[0] is the live input.
  logic [MAX_DELAY-1:0] taps;
  logic [DLY_W-1:0]     sel;
  logic                 mis;
  logic [EW-1:0]        acc_sum;
  logic                 win_end;
  logic                 better;

  assign taps    = {hist_q, sx};
  assign sel     = (state_q == ST_LOCKED) ? delay_q : trial_q;
  assign mis     = dx ^ taps[sel];
  assign acc_sum = acc_q + EW'(mis);
  assign win_end = (win_q == WIN_LAST);
  assign better  = (acc_sum < min_q);

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    trial_d   = trial_q;
    min_dly_d = min_dly_q;
    delay_d   = delay_q;
    win_d     = win_q;
    acc_d     = acc_q;
    min_d     = min_q;
    err_d     = err_q;
    bit_d     = bit_q;

    if (enable) begin
      hist_d = taps[MAX_DELAY-2:0];
      win_d  = win_end ? '0 : win_q + WC_W'(1);
      acc_d  = win_end ? '0 : acc_sum;
      if (clear) begin
        err_d = '0;
        bit_d = '0;
      end

      case (state_q)
        ST_SEARCH: begin
          if (win_end) begin
            if (better) begin
              min_d     = acc_sum;
              min_dly_d = trial_q;
            end
            if (trial_q == DLY_LAST) begin
              state_d   = ST_LOCKED;
              delay_d   = better ? trial_q : min_dly_q;
              trial_d   = '0;
              min_d     = '1;
              min_dly_d = '0;
            end else begin
              trial_d = trial_q + DLY_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!clear) begin
            bit_d = (bit_q == '1) ? bit_q : bit_q + CNT_W'(1);
            err_d = (err_q == '1) ? err_q : err_q + CNT_W'(mis);
          end
          if (win_end && (32'(acc_sum) > RELOCK_THR)) begin
            state_d   = ST_SEARCH;
            trial_d   = '0;
            min_d     = '1;
            min_dly_d = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    flag_d = (err_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SEARCH;
      hist_q    <= '0;
      trial_q   <= '0;
      min_dly_q <= '0;
      delay_q   <= '0;
      win_q     <= '0;
      acc_q     <= '0;
      min_q     <= '1;
      err_q     <= '0;
      bit_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      trial_q   <= trial_d;
      min_dly_q <= min_dly_d;
      delay_q   <= delay_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      min_q     <= min_d;
      err_q     <= err_d;
      bit_q     <= bit_d;
      flag_q    <= flag_d;
    end
  end

  assign state      = state_q;
  assign delay      = delay_q;
  assign err_count  = err_q;
  assign bit_count  = bit_q;
  assign error_flag = flag_q;

endmodule

// File: rtl/ber_sync.sv
// Multi-lane BER synchroniser: one independent ber_lane per bit lane,
// outputs packed lane 0 in the least significant slice.
module ber_sync
  import ber_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int MAX_DELAY  = DEF_MAX_DELAY,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int RELOCK_THR = DEF_RELOCK_THR,
  parameter int CNT_W      = DEF_CNT_W,
  localparam int DLY_W     = $clog2(MAX_DELAY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NCH-1:0]       sx,
  input  logic [NCH-1:0]       dx,
  input  logic                 clear,
  output logic [NCH-1:0]       locked,
  output logic [NCH*DLY_W-1:0] delay,
  output logic [NCH*CNT_W-1:0] err_count,
  output logic [NCH*CNT_W-1:0] bit_count,
  output logic [NCH-1:0]       error_flag
);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    lane_state_t st;

    ber_lane #(
      .MAX_DELAY  (MAX_DELAY),
      .WIN_LEN    (WIN_LEN),
      .RELOCK_THR (RELOCK_THR),
      .CNT_W      (CNT_W),
      .DLY_W      (DLY_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .sx         (sx[i]),
      .dx         (dx[i]),
      .clear      (clear),
      .state      (st),
      .delay      (delay[i*DLY_W +: DLY_W]),
      .err_count  (err_count[i*CNT_W +: CNT_W]),
      .bit_count  (bit_count[i*CNT_W +: CNT_W]),
      .error_flag (error_flag[i])
    );

    assign locked[i] = (st == ST_LOCKED);
  end

endmodule

// File: tb/tb_ber_sync.sv
// Bench for ber_sync: PRBS9 stimulus through per-lane delay channels, a
// behavioural reference compared every cycle, plus literal scenario checks.
module tb_ber_sync;

  localparam int NCH        = 2;
  localparam int MAX_DELAY  = 16;
  localparam int WIN_LEN    = 64;
  localparam int RELOCK_THR = 8;
  localparam int CNT_W      = 32;
  localparam int DLY_W      = 4;
  localparam longint MAXC   = (64'd1 << CNT_W) - 1;

  // clock / reset / DUT
  logic clk = 1'b0;
  logic rst, enable, clear;
  logic [NCH-1:0]       sx, dx;
  logic [NCH-1:0]       locked, error_flag;
  logic [NCH*DLY_W-1:0] delay;
  logic [NCH*CNT_W-1:0] err_count, bit_count;

  always #5 clk = ~clk;

  ber_sync #(
    .NCH(NCH), .MAX_DELAY(MAX_DELAY), .WIN_LEN(WIN_LEN),
    .RELOCK_THR(RELOCK_THR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sx(sx), .dx(dx), .clear(clear),
    .locked(locked), .delay(delay), .err_count(err_count),
    .bit_count(bit_count), .error_flag(error_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input int lane, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s lane%0d actual=%0d expected=%0d at %0t", name, lane, act, exp, $time);
    end
  endtask

  // channel generator: PRBS9 source and a configurable delay per lane
  logic [8:0] prbs[NCH];
  int         gen_dly[NCH];
  bit         gen_hist[NCH][MAX_DELAY];
  bit         flip[NCH];

  task automatic step(input bit en, input bit clr, input bit r);
    rst    = r;
    enable = en;
    clear  = clr;
    for (int l = 0; l < NCH; l++) begin
      if (en) begin
        bit sb, db;
        sb = prbs[l][8] ^ prbs[l][4];
        prbs[l] = {prbs[l][7:0], sb};
        db = (gen_dly[l] == 0) ? sb : gen_hist[l][gen_dly[l]-1];
        db = db ^ flip[l];
        flip[l] = 1'b0;
        for (int k = MAX_DELAY - 1; k > 0; k--) gen_hist[l][k] = gen_hist[l][k-1];
        gen_hist[l][0] = sb;
        sx[l] = sb;
        dx[l] = db;
      end else begin
        sx[l] = 1'($urandom);
        dx[l] = 1'($urandom);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // behavioural reference: per-trial error table, argmin at sweep end
  bit     m_locked[NCH];
  int     m_delay[NCH];
  longint m_err[NCH], m_bit[NCH];
  int     m_trial[NCH], m_widx[NCH], m_mon[NCH];
  int     m_terr[NCH][MAX_DELAY];
  bit     m_hist[NCH][MAX_DELAY];

  always @(posedge clk) begin
    for (int l = 0; l < NCH; l++) begin
      if (rst) begin
        m_locked[l] = 1'b0; m_delay[l] = 0; m_err[l] = 0; m_bit[l] = 0;
        m_trial[l] = 0; m_widx[l] = 0; m_mon[l] = 0;
        for (int k = 0; k < MAX_DELAY; k++) begin
          m_terr[l][k] = 0;
          m_hist[l][k] = 1'b0;
        end
      end else if (enable) begin
        int d, best;
        bit rb, mis;
        d   = m_locked[l] ? m_delay[l] : m_trial[l];
        rb  = (d == 0) ? sx[l] : m_hist[l][d-1];
        mis = dx[l] ^ rb;
        if (clear) begin
          m_err[l] = 0;
          m_bit[l] = 0;
        end
        if (!m_locked[l]) begin
          m_terr[l][m_trial[l]] += int'(mis);
          m_widx[l]++;
          if (m_widx[l] == WIN_LEN) begin
            m_widx[l] = 0;
            if (m_trial[l] == MAX_DELAY - 1) begin
              best = 0;
              for (int k = 1; k < MAX_DELAY; k++)
                if (m_terr[l][k] < m_terr[l][best]) best = k;
              m_locked[l] = 1'b1;
              m_delay[l]  = best;
              m_trial[l]  = 0;
            end else begin
              m_trial[l]++;
            end
          end
        end else begin
          if (!clear) begin
            m_bit[l] = (m_bit[l] + 1 > MAXC) ? MAXC : m_bit[l] + 1;
            m_err[l] = (m_err[l] + mis > MAXC) ? MAXC : m_err[l] + mis;
          end
          m_mon[l] += int'(mis);
          m_widx[l]++;
          if (m_widx[l] == WIN_LEN) begin
            if (m_mon[l] > RELOCK_THR) begin
              m_locked[l] = 1'b0;
              m_trial[l]  = 0;
              for (int k = 0; k < MAX_DELAY; k++) m_terr[l][k] = 0;
            end
            m_widx[l] = 0;
            m_mon[l]  = 0;
          end
        end
        for (int k = MAX_DELAY - 1; k > 0; k--) m_hist[l][k] = m_hist[l][k-1];
        m_hist[l][0] = sx[l];
      end
    end
  end

  // scoreboard: every output of every lane against the reference each cycle
  always @(negedge clk) begin
    if (chk_on) begin
      for (int l = 0; l < NCH; l++) begin
        chk("locked",     l, longint'(locked[l]),                 longint'(m_locked[l]));
        chk("delay",      l, longint'(delay[l*DLY_W +: DLY_W]),   longint'(m_delay[l]));
        chk("err_count",  l, longint'(err_count[l*CNT_W +: CNT_W]), m_err[l]);
        chk("bit_count",  l, longint'(bit_count[l*CNT_W +: CNT_W]), m_bit[l]);
        chk("error_flag", l, longint'(error_flag[l]),             longint'(m_err[l] != 0));
      end
    end
  end

  function automatic longint err_of(input int l);
    return longint'(err_count[l*CNT_W +: CNT_W]);
  endfunction

  function automatic longint dly_of(input int l);
    return longint'(delay[l*DLY_W +: DLY_W]);
  endfunction

  initial begin
    bit     seen;
    int     en_cnt, cyc;
    longint err_hold;

    rst = 1'b1; enable = 1'b0; clear = 1'b0; sx = '0; dx = '0;
    prbs[0] = 9'h1ff; prbs[1] = 9'h0a5;
    gen_dly[0] = 5; gen_dly[1] = 11;
    for (int l = 0; l < NCH; l++) begin
      flip[l] = 1'b0;
      for (int k = 0; k < MAX_DELAY; k++) gen_hist[l][k] = 1'b0;
    end
    chk_on = 1'b1;

    // reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_locked", 0, longint'(locked), 0);
    chk("rst_delay",  0, longint'(delay), 0);
    chk("rst_err",    0, longint'(err_count), 0);
    chk("rst_bits",   0, longint'(bit_count), 0);
    chk("rst_flag",   0, longint'(error_flag), 0);

    // first lock: lane delays 5 and 11
    for (int i = 0; i < 1023; i++) step(1'b1, 1'b0, 1'b0);
    chk("lock_early", 0, longint'(locked), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("lock_both", 0, longint'(locked), 3);
    chk("lock_dly", 0, dly_of(0), 5);
    chk("lock_dly", 1, dly_of(1), 11);
    chk("lock_err", 0, longint'(err_count), 0);
    chk("model_dly", 0, longint'(m_delay[0]), 5);
    chk("model_dly", 1, longint'(m_delay[1]), 11);

    // three isolated bit errors on lane 0
    for (int i = 0; i < 200; i++) begin
      if (i == 20 || i == 80 || i == 140) flip[0] = 1'b1;
      step(1'b1, 1'b0, 1'b0);
    end
    chk("flip_err",    0, err_of(0), 3);
    chk("flip_flag",   0, longint'(error_flag[0]), 1);
    chk("flip_locked", 0, longint'(locked[0]), 1);
    chk("flip_bits",   0, longint'(bit_count[0 +: CNT_W]), 200);
    chk("flip_err",    1, err_of(1), 0);
    chk("flip_locked", 1, longint'(locked[1]), 1);

    // clear while locked
    step(1'b1, 1'b1, 1'b0);
    chk("clear_err",    0, longint'(err_count), 0);
    chk("clear_bits",   0, longint'(bit_count), 0);
    chk("clear_locked", 0, longint'(locked), 3);

    // lane 0 channel delay moves to 7: lose lock, then relock
    gen_dly[0] = 7;
    seen = 1'b0;
    for (int i = 0; i < WIN_LEN && !seen; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (!locked[0]) seen = 1'b1;
    end
    chk("unlock_seen", 0, longint'(seen), 1);
    err_hold = err_of(0);
    chk("unlock_err_nonzero", 0, longint'(err_hold != 0), 1);
    for (int i = 0; i < 1023; i++) step(1'b1, 1'b0, 1'b0);
    chk("relock_early", 0, longint'(locked[0]), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("relock",        0, longint'(locked[0]), 1);
    chk("relock_dly",    0, dly_of(0), 7);
    chk("relock_kept",   0, err_of(0), err_hold);
    chk("relock_other",  1, longint'(locked[1]), 1);

    // reset at sample 500 of a sweep
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("mid_rst_locked", 0, longint'(locked), 0);
    chk("mid_rst_delay",  0, longint'(delay), 0);
    chk("mid_rst_err",    0, longint'(err_count), 0);
    chk("mid_rst_bits",   0, longint'(bit_count), 0);
    for (int i = 0; i < 1023; i++) step(1'b1, 1'b0, 1'b0);
    chk("rst_relock_early", 0, longint'(locked), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_relock", 0, longint'(locked), 3);
    chk("rst_relock_dly", 0, dly_of(0), 7);
    chk("rst_relock_dly", 1, dly_of(1), 11);

    // random 50% enable
    gen_dly[0] = 5;
    step(1'b0, 1'b0, 1'b1);
    en_cnt = 0;
    cyc = 0;
    while (en_cnt < 1024 && cyc < 5000) begin
      bit e;
      e = 1'($urandom_range(0, 1));
      step(e, 1'b0, 1'b0);
      en_cnt += int'(e);
      cyc++;
    end
    chk("gated_budget", 0, longint'(en_cnt), 1024);
    chk("gated_lock", 0, longint'(locked), 3);
    chk("gated_dly", 0, dly_of(0), 5);
    chk("gated_dly", 1, dly_of(1), 11);
    chk("gated_err", 0, longint'(err_count), 0);

    // random stress: errors, clears, delay changes, rare resets
    for (int i = 0; i < 4000; i++) begin
      if (i % 1300 == 0)
        for (int l = 0; l < NCH; l++) gen_dly[l] = $urandom_range(0, MAX_DELAY - 1);
      for (int l = 0; l < NCH; l++)
        if ($urandom_range(0, 29) == 0) flip[l] = 1'b1;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 1999) == 0));
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_sync.md
BER_SYNC -- requirements
Module: ber_sync

Interface
REQ-001 Parameter NCH, default 2: number of independent bit lanes (I, Q).
REQ-002 Parameter MAX_DELAY, default 511: number of candidate alignments searched, delays 0..MAX_DELAY-1.
REQ-003 Parameter WIN_LEN, default 511: enabled samples per alignment trial and per lock-monitor window.
REQ-004 Parameter RELOCK_THR, default 32: monitor-window errors above this value mean loss of lock.
REQ-005 Parameter CNT_W, default 32: width of the error and bit counters.
REQ-006 clk  input  1  single clock; every register updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 enable  input  1  sample strobe; all state holds while low.
REQ-009 sx  input  NCH  reference (transmitted) bit per lane.
REQ-010 dx  input  NCH  received bit per lane.
REQ-011 clear  input  1  zeroes the error and bit counters of all lanes; lock state is unaffected.
REQ-012 locked  output  NCH  lane is in the LOCKED state.
REQ-013 delay  output  NCH*DLY_W  chosen delay per lane, where DLY_W = $clog2(MAX_DELAY).
REQ-014 err_count  output  NCH*CNT_W  accumulated errors per lane while locked.
REQ-015 bit_count  output  NCH*CNT_W  compared bits per lane while locked.
REQ-016 error_flag  output  NCH  high when the lane's err_count is nonzero.

Function
REQ-017 Each lane keeps an sx history of MAX_DELAY samples; the history shifts on every enabled cycle, in either state.
REQ-018 Delay d means dx(n) is compared with sx(n-d) in enabled-sample time; d=0 compares against the current sx.
REQ-019 The lane FSM has two states, SEARCH and LOCKED; it enters SEARCH with trial delay 0 and the running minimum all ones.
REQ-020 In SEARCH, each trial accumulates the mismatches at trial delay d over exactly WIN_LEN enabled samples.
REQ-021 The next trial starts on the next enabled sample with no idle sample, so a full sweep takes MAX_DELAY*WIN_LEN enabled samples.
REQ-022 A trial's count replaces the running minimum only when strictly smaller; ties keep the lowest delay.
REQ-023 After trial MAX_DELAY-1 the lane goes to LOCKED and delay takes the minimum-error delay, both visible the cycle after that trial's last sample.
REQ-024 In LOCKED, each enabled sample increments bit_count by 1 and err_count by the mismatch bit.
REQ-025 In LOCKED, a monitor window of WIN_LEN samples counts errors; if the count exceeds RELOCK_THR the lane returns to SEARCH at trial delay 0.
REQ-026 On return to SEARCH, err_count and bit_count are retained and locked drops the following cycle.
REQ-027 err_count and bit_count saturate at all ones and never wrap.
REQ-028 When clear and enable are both high, clear wins: counters go to 0 and that sample is not counted, but the history still shifts.
REQ-029 Lanes are fully independent; each lane's results depend on its own sx/dx bits only.
REQ-030 All outputs are registered.

Reset
REQ-031 While rst is high at a clock edge: history zeroed, state SEARCH, trial delay 0, minimum all ones.
REQ-032 Reset outputs: locked=0, delay=0, err_count=0, bit_count=0, error_flag=0.
REQ-033 rst takes priority over enable and clear; reset mid-search or mid-lock restarts the sweep from delay 0.

Structure
REQ-034 Shared package ber_pkg holds the FSM state encoding and the default parameter constants (MAX_DELAY, WIN_LEN, RELOCK_THR, CNT_W).
REQ-035 One sub-module, ber_lane, implements one lane (history, FSM, counters); ber_sync generates NCH instances and packs the outputs.

Verification
Common bench settings: NCH=2, MAX_DELAY=16, WIN_LEN=64, RELOCK_THR=8, sx = PRBS9.
REQ-036 dx0 = sx0 delayed 5, dx1 = sx1 delayed 11 -> after 1024 enabled samples: locked=11, delay0=5, delay1=11, err_count=0.
REQ-037 After lock, flip 3 isolated dx0 bits -> err_count0=3, error_flag0=1, locked0 stays 1, lane 1 unaffected.
REQ-038 After lock, change lane-0 delay to 7 -> locked0 falls within 64 samples, then relocks with delay0=7 after 1024 more samples, err_count0 retained.
REQ-039 Assert clear and enable in the same cycle while locked -> err_count=0 and bit_count=0 next cycle, locked unchanged.
REQ-040 Assert rst at sample 500 of a sweep -> all outputs 0; the sweep restarts and locks 1024 enabled samples after rst is released.
REQ-041 Repeat REQ-036 with enable toggled at random 50% duty -> identical delay and lock after 1024 enabled samples.
